// File: rtl/systolic_drain_5x5_if.sv
// Row output stream of systolic_drain_5x5: aligned row data with valid/ready and last-row flag.
interface systolic_drain_5x5_if #(
    parameter int AK_BW = 20,
    parameter int COLS  = 5
);
    logic [AK_BW*COLS-1:0] o_row_data;
    logic                  o_row_valid;
    logic                  i_row_ready;
    logic                  o_row_last;

    modport master (
        output o_row_data,
        output o_row_valid,
        output o_row_last,
        input  i_row_ready
    );

    modport slave (
        input  o_row_data,
        input  o_row_valid,
        input  o_row_last,
        output i_row_ready
    );
endinterface

// File: rtl/systolic_drain_5x5.sv
// Deskews skewed column sums from the 5x5 systolic array into rows, buffers them and streams them out.
// Optional macro SYSTOLIC_DRAIN_RELU_EN clamps negative column values to zero at the aligned write.
module systolic_drain_5x5 #(
    parameter int AK_BW  = 20,
    parameter int COLS   = 5,
    parameter int DEPTH  = 4,
    parameter int CNT_BW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [CNT_BW-1:0]     i_num_rows,
    input  logic [AK_BW*COLS-1:0] i_acc_kernel,
    input  logic [COLS-1:0]       i_col_vld,
    output logic                  o_accept,
    systolic_drain_5x5_if.master  row_if,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int RW = AK_BW * COLS;

    // states: IDLE waits for start | COLLECT deskews and stores rows | DRAIN empties the FIFO
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_BW-1:0] num_rows_q, num_rows_d;
    logic [CNT_BW-1:0] launched_q, launched_d;
    logic [CNT_BW-1:0] written_q, written_d;
    logic [CNT_BW-1:0] popped_q, popped_d;
    logic [CNT_BW-1:0] inflight_q, inflight_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic              collect;
    logic [COLS-1:0]   vld_in;
    logic [COLS-1:0]   al_vld;
    logic [AK_BW-1:0]  al_data [COLS];
    logic [COLS-2:0]   bad_q;
    logic              aligned_all;
    logic              misalign;
    logic [RW-1:0]     wdata;
    logic [AK_BW-1:0]  col_v;

    logic [RW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q;
    logic              full, push, pop, drop, row_valid, row_last;
    logic [CNT_BW:0]   occ;

    assign collect = (state_q == ST_COLLECT);
    assign vld_in  = i_col_vld & {COLS{collect}};

    // Column c enters a chain of COLS-1-c registers so all columns of a row meet at the last column.
    for (genvar c = 0; c < COLS - 1; c++) begin : g_dly
        localparam int N = COLS - 1 - c;
        logic [AK_BW-1:0] d_q [N];
        logic [N-1:0]     v_q;

        always_ff @(posedge clk) begin
            if (rst || !collect) begin
                v_q <= '0;
            end else begin
                v_q[0] <= vld_in[c];
                for (int k = 1; k < N; k++) v_q[k] <= v_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            d_q[0] <= i_acc_kernel[c*AK_BW +: AK_BW];
            for (int k = 1; k < N; k++) d_q[k] <= d_q[k-1];
        end

        assign al_data[c] = d_q[N-1];
        assign al_vld[c]  = v_q[N-1];
    end

    assign al_data[COLS-1] = i_acc_kernel[(COLS-1)*AK_BW +: AK_BW];
    assign al_vld[COLS-1]  = vld_in[COLS-1];

    // Rows launched without o_accept carry a tag alongside column 0 so the error lands at their write.
    always_ff @(posedge clk) begin
        if (rst || !collect) begin
            bad_q <= '0;
        end else begin
            bad_q[0] <= vld_in[0] & ~o_accept;
            for (int k = 1; k < COLS - 1; k++) bad_q[k] <= bad_q[k-1];
        end
    end

    assign aligned_all = &al_vld;
    assign misalign    = (|al_vld) && !aligned_all;

    always_comb begin
        wdata = '0;
        col_v = '0;
        for (int c = 0; c < COLS; c++) begin
            col_v = al_data[c];
`ifdef SYSTOLIC_DRAIN_RELU_EN
            if (col_v[AK_BW-1]) col_v = '0;
`endif
            wdata[c*AK_BW +: AK_BW] = col_v;
        end
    end

    assign full      = (count_q == (PW+1)'(DEPTH));
    assign row_valid = (count_q != '0);
    assign pop       = row_valid && row_if.i_row_ready;
    assign push      = aligned_all && (!full || pop);
    assign drop      = aligned_all && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    assign occ      = (CNT_BW+1)'(count_q) + (CNT_BW+1)'(inflight_q);
    assign o_accept = collect && (occ < (CNT_BW+1)'(DEPTH)) && (launched_q < num_rows_q);
    assign row_last = row_valid && (popped_q == num_rows_q - CNT_BW'(1));

    always_comb begin
        state_d    = state_q;
        num_rows_d = num_rows_q;
        launched_d = launched_q + CNT_BW'(vld_in[0]);
        written_d  = written_q + CNT_BW'(push);
        popped_d   = popped_q + CNT_BW'(pop);
        inflight_d = inflight_q + CNT_BW'(vld_in[0]) - CNT_BW'(aligned_all);
        err_d      = err_q | misalign | drop | (aligned_all & bad_q[COLS-2]);
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_COLLECT;
                    num_rows_d = (i_num_rows == '0) ? CNT_BW'(1) : i_num_rows;
                    launched_d = '0;
                    written_d  = '0;
                    popped_d   = '0;
                    inflight_d = '0;
                    err_d      = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (written_d == num_rows_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && row_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            num_rows_q <= '0;
            launched_q <= '0;
            written_q  <= '0;
            popped_q   <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
            launched_q <= launched_d;
            written_q  <= written_d;
            popped_q   <= popped_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign row_if.o_row_data  = row_valid ? mem_q[rd_ptr_q] : '0;
    assign row_if.o_row_valid = row_valid;
    assign row_if.o_row_last  = row_last;
    assign o_busy             = (state_q != ST_IDLE);
    assign o_done             = done_q;
    assign o_err              = err_q;

endmodule

// File: tb/tb_systolic_drain_5x5.sv
// Directed and randomized bench for systolic_drain_5x5 against a row-level reference model.
module tb_systolic_drain_5x5;
    localparam int AK_BW  = 20;
    localparam int COLS   = 5;
    localparam int DEPTH  = 4;
    localparam int CNT_BW = 8;
    localparam int RW     = AK_BW * COLS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic [CNT_BW-1:0] i_num_rows = '0;
    logic [RW-1:0]     i_acc_kernel = '0;
    logic [COLS-1:0]   i_col_vld = '0;
    logic              o_accept, o_busy, o_done, o_err;

    systolic_drain_5x5_if #(.AK_BW(AK_BW), .COLS(COLS)) rif ();

    systolic_drain_5x5 #(.AK_BW(AK_BW), .COLS(COLS), .DEPTH(DEPTH), .CNT_BW(CNT_BW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_num_rows   (i_num_rows),
        .i_acc_kernel (i_acc_kernel),
        .i_col_vld    (i_col_vld),
        .o_accept     (o_accept),
        .row_if       (rif),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [RW-1:0] hrow [6];
    bit            hvld [6];
    int            skew [COLS];
    logic [RW-1:0] exp_q [$];
    int            m_num = 0;
    int            m_launched = 0;
    int            m_popped = 0;
    bit            m_active = 1'b0;
    bit            m_done_pending = 1'b0;
    int            relu_vals [COLS] = '{-5, 7, -1, 0, 3};

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int c = 0; c < COLS; c++) r[c*AK_BW +: AK_BW] = AK_BW'($urandom);
        return r;
    endfunction

    function automatic logic [RW-1:0] ref_row(input logic [RW-1:0] r);
        logic [RW-1:0] o;
        o = r;
`ifdef SYSTOLIC_DRAIN_RELU_EN
        for (int c = 0; c < COLS; c++)
            if (r[c*AK_BW + AK_BW - 1]) o[c*AK_BW +: AK_BW] = '0;
`endif
        return o;
    endfunction

    // hist[k] is the row launched k cycles ago; column c reads the row launched c (+skew) cycles ago
    task automatic drive(input bit launch, input logic [RW-1:0] row, input bit rdy);
        for (int k = 5; k > 0; k--) begin
            hrow[k] = hrow[k-1];
            hvld[k] = hvld[k-1];
        end
        hrow[0] = row;
        hvld[0] = launch;
        for (int c = 0; c < COLS; c++) begin
            i_col_vld[c] = hvld[c + skew[c]];
            i_acc_kernel[c*AK_BW +: AK_BW] = hrow[c + skew[c]][c*AK_BW +: AK_BW];
        end
        rif.i_row_ready = rdy;
    endtask

    task automatic step(input bit want, input bit obey, input bit expect_out, input bit rdy,
                        input logic [RW-1:0] row, input logic [RW-1:0] exp_row);
        bit exp_acc, do_launch, is_last;
        @(negedge clk);
        exp_acc = m_active && (m_launched < m_num) && ((m_launched - m_popped) < DEPTH);
        chk("accept", o_accept, exp_acc);
        chk("done", o_done, m_done_pending);
        chk("busy", o_busy, m_active);
        m_done_pending = 1'b0;
        i_start = 1'b0;
        do_launch = want && (!obey || exp_acc);
        drive(do_launch, row, rdy);
        if (do_launch) begin
            m_launched++;
            if (expect_out) exp_q.push_back(exp_row);
        end
        if (rif.o_row_valid) begin
            is_last = (m_popped == m_num - 1);
            chk("row_last", rif.o_row_last, is_last);
            if (rdy) begin
                chk("row_avail", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) chk("row_data", rif.o_row_data, exp_q.pop_front());
                m_popped++;
                if (is_last) begin
                    m_done_pending = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
    endtask

    task automatic start_job(input int n);
        @(negedge clk);
        chk("start_done", o_done, m_done_pending);
        chk("start_idle", o_busy, 1'b0);
        i_start = 1'b1;
        i_num_rows = CNT_BW'(n);
        drive(1'b0, '0, 1'b0);
        m_num = (n == 0) ? 1 : n;
        m_launched = 0;
        m_popped = 0;
        m_active = 1'b1;
        m_done_pending = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_start = 1'b0;
        i_num_rows = '0;
        for (int k = 0; k < 6; k++) begin
            hrow[k] = '0;
            hvld[k] = 1'b0;
        end
        i_col_vld = '0;
        i_acc_kernel = '0;
        rif.i_row_ready = 1'b0;
        m_active = 1'b0;
        m_done_pending = 1'b0;
        m_num = 0;
        m_launched = 0;
        m_popped = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("rst_accept", o_accept, 1'b0);
        chk("rst_valid", rif.o_row_valid, 1'b0);
        chk("rst_data", rif.o_row_data, '0);
        chk("rst_last", rif.o_row_last, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_err", o_err, 1'b0);
    endtask

    task automatic run_job(input int n, input int hold, input int budget);
        int cyc = 0;
        logic [RW-1:0] r;
        start_job(n);
        while (m_popped < m_num && cyc < budget) begin
            r = rand_row();
            step(1'b1, 1'b1, 1'b1, (cyc >= hold) && ($urandom_range(0, 1) == 1), r, ref_row(r));
            cyc++;
        end
        chk("job_timeout", cyc < budget, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        chk("job_err", o_err, 1'b0);
    endtask

    initial begin
        logic [RW-1:0] r, rexp;
        int cyc;
        int v;
        rif.i_row_ready = 1'b0;
        for (int c = 0; c < COLS; c++) skew[c] = 0;
        for (int k = 0; k < 6; k++) begin
            hrow[k] = '0;
            hvld[k] = 1'b0;
        end
        do_reset();

        // single row, exact latency of five cycles
        start_job(1);
        for (int c = 0; c < COLS; c++) r[c*AK_BW +: AK_BW] = AK_BW'(10 * (c + 1));
        step(1'b1, 1'b1, 1'b1, 1'b0, r, r);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 1'b1, (k == 5), '0, '0);
            chk("lat_valid", rif.o_row_valid, (k == 5));
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        chk("lat_err", o_err, 1'b0);

        // ready held low for a while, accept must throttle at DEPTH
        run_job(6, 15, 300);
        // zero row count behaves as one
        run_job(0, 0, 100);

        // fifth row forced in while full, popped in the same cycle it is written
        start_job(5);
        for (int k = 0; k < 4; k++) begin
            r = rand_row();
            step(1'b1, 1'b1, 1'b1, 1'b0, r, ref_row(r));
        end
        r = rand_row();
        step(1'b1, 1'b0, 1'b1, 1'b0, r, ref_row(r));
        for (int k = 5; k < 8; k++) step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        chk("full_hold_valid", rif.o_row_valid, 1'b1);
        cyc = 0;
        while (m_popped < m_num && cyc < 30) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
            cyc++;
        end
        chk("full_timeout", cyc < 30, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        chk("full_err", o_err, 1'b1);

        // column 3 one cycle late: sticky error, no row written
        start_job(2);
        skew[3] = 1;
        r = rand_row();
        step(1'b1, 1'b1, 1'b0, 1'b0, r, '0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        skew[3] = 0;
        chk("mis_err", o_err, 1'b1);
        chk("mis_valid", rif.o_row_valid, 1'b0);
        chk("mis_busy", o_busy, 1'b1);
        do_reset();

        // reset after two of four rows are written
        start_job(4);
        for (int k = 0; k < 4; k++) begin
            r = rand_row();
            step(1'b1, 1'b1, 1'b1, 1'b0, r, ref_row(r));
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        chk("mid_valid", rif.o_row_valid, 1'b1);
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
        chk("mid_flushed", rif.o_row_valid, 1'b0);
        run_job(3, 2, 200);

        // clamp behaviour on a fixed mixed-sign row
        start_job(1);
        for (int c = 0; c < COLS; c++) begin
            r[c*AK_BW +: AK_BW] = AK_BW'(relu_vals[c]);
            v = relu_vals[c];
`ifdef SYSTOLIC_DRAIN_RELU_EN
            if (v < 0) v = 0;
`endif
            rexp[c*AK_BW +: AK_BW] = AK_BW'(v);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, r, rexp);
        cyc = 0;
        while (m_popped < 1 && cyc < 20) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
            cyc++;
        end
        chk("relu_timeout", cyc < 20, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);

        for (int i = 0; i < 4; i++) run_job($urandom_range(1, 9), $urandom_range(0, 12), 400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
